// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bus: instruction-memory request/response and the buffered
// instruction handed to decode.
interface pc_fetch_unit_if #(
   parameter int ADDR_W  = 20,
   parameter int INSTR_W = 32
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic               inst_valid;
   logic [INSTR_W-1:0] inst_data;
   logic [ADDR_W-1:0]  inst_pc;
   logic               inst_ready;

   modport master (
      output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
      input  imem_ack, imem_rdata, inst_ready
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
      output imem_ack, imem_rdata, inst_ready
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction-fetch sequencer with a
// one-entry instruction buffer toward decode.
module pc_fetch_unit #(
   parameter int                ADDR_W   = 20,
   parameter int                INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_run,
   input  logic                 i_redirect_valid,
   input  logic [ADDR_W-1:0]    i_redirect_pc,
   output logic                 o_pc_wrap,
   pc_fetch_unit_if.master      bus
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t             r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic               r_req;
   logic               r_inst_valid;
   logic [INSTR_W-1:0] r_inst_data;
   logic [ADDR_W-1:0]  r_inst_pc;
   logic               r_pc_wrap;
   logic [ADDR_W:0]    w_pc_inc;

   // Top bit is the incrementer carry-out, i.e. the PC wrapping to zero.
   assign w_pc_inc = {1'b0, r_pc} + {{ADDR_W{1'b0}}, 1'b1};

   assign bus.imem_req   = r_req;
   assign bus.imem_addr  = r_pc;
   assign bus.inst_valid = r_inst_valid;
   assign bus.inst_data  = r_inst_data;
   assign bus.inst_pc    = r_inst_pc;
   assign o_pc_wrap      = r_pc_wrap;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_req        <= 1'b0;
         r_inst_valid <= 1'b0;
         r_inst_data  <= '0;
         r_inst_pc    <= '0;
         r_pc_wrap    <= 1'b0;
      end else if (i_redirect_valid) begin
         // Any in-flight response or buffered instruction is dropped.
         r_pc         <= i_redirect_pc;
         r_inst_valid <= 1'b0;
         r_pc_wrap    <= 1'b0;
         r_state      <= i_run ? REQ : IDLE;
         r_req        <= i_run;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_run) begin
                  r_state <= REQ;
                  r_req   <= 1'b1;
               end
            end
            REQ: begin
               if (bus.imem_ack) begin
                  r_inst_data  <= bus.imem_rdata;
                  r_inst_pc    <= r_pc;
                  r_inst_valid <= 1'b1;
                  r_pc         <= w_pc_inc[ADDR_W-1:0];
                  if (w_pc_inc[ADDR_W]) r_pc_wrap <= 1'b1;
                  r_state      <= HOLD;
                  r_req        <= 1'b0;
               end
            end
            HOLD: begin
               if (bus.inst_ready) begin
                  r_inst_valid <= 1'b0;
                  r_state      <= i_run ? REQ : IDLE;
                  r_req        <= i_run;
               end
            end
            default: begin
               r_state <= IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed fetch scenarios followed by randomized traffic, each cycle compared
// against a transaction-level model of the fetch unit.
module tb_pc_fetch_unit;
   localparam int AW = 20;
   localparam int IW = 32;

   logic          clk = 1'b0;
   logic          rst, run, rv;
   logic [AW-1:0] rpc;
   logic          pc_wrap;

   pc_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

   pc_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC('0)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_run            (run),
      .i_redirect_valid (rv),
      .i_redirect_pc    (rpc),
      .o_pc_wrap        (pc_wrap),
      .bus              (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: request outstanding / instruction buffered flags.
   logic [AW-1:0] m_pc;
   logic          m_busy, m_full, m_wrap;
   logic [IW-1:0] m_data;
   logic [AW-1:0] m_ipc;

   function automatic logic [IW-1:0] memf(input logic [AW-1:0] a);
      return {a[11:0], a} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   task automatic cyc(input logic i_rst_v, input logic i_run_v, input logic i_rv,
                      input logic [AW-1:0] i_rpc, input logic i_ack, input logic i_rdy);
      @(negedge clk);
      chk("imem_req",   {31'd0, bus.imem_req},   {31'd0, m_busy});
      chk("imem_addr",  {12'd0, bus.imem_addr},  {12'd0, m_pc});
      chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_full});
      chk("inst_data",  bus.inst_data,           m_data);
      chk("inst_pc",    {12'd0, bus.inst_pc},    {12'd0, m_ipc});
      chk("pc_wrap",    {31'd0, pc_wrap},        {31'd0, m_wrap});
      rst = i_rst_v; run = i_run_v; rv = i_rv; rpc = i_rpc;
      bus.imem_ack   = i_ack;
      bus.imem_rdata = memf(bus.imem_addr);
      bus.inst_ready = i_rdy;
      // Model effect of the coming rising edge.
      if (i_rst_v) begin
         m_pc = '0; m_busy = 0; m_full = 0; m_wrap = 0; m_data = '0; m_ipc = '0;
      end else if (i_rv) begin
         m_pc = i_rpc; m_full = 0; m_wrap = 0; m_busy = i_run_v;
      end else if (m_busy && i_ack) begin
         m_data = memf(m_pc); m_ipc = m_pc; m_full = 1; m_busy = 0;
         if (m_pc == {AW{1'b1}}) m_wrap = 1;
         m_pc = m_pc + 1'b1;
      end else if (m_full && i_rdy) begin
         m_full = 0; m_busy = i_run_v;
      end else if (!m_busy && !m_full && i_run_v) begin
         m_busy = 1;
      end
   endtask

   initial begin
      rst = 1; run = 0; rv = 0; rpc = '0;
      bus.imem_ack = 0; bus.imem_rdata = '0; bus.inst_ready = 0;
      @(posedge clk);
      m_pc = '0; m_busy = 0; m_full = 0; m_wrap = 0; m_data = '0; m_ipc = '0;
      cyc(1, 0, 0, '0, 0, 0);
      // Streaming fetch with immediate acks and ready decode
      for (int i = 0; i < 10; i++) cyc(0, 1, 0, '0, 1, 1);
      // Decode stalls while an instruction is buffered
      for (int i = 0; i < 6; i++) cyc(0, 1, 0, '0, 1, 0);
      cyc(0, 1, 0, '0, 1, 1);
      // Fetch from the top address: PC wraps and the sticky flag sets
      cyc(0, 1, 1, 20'hFFFFF, 0, 1);
      for (int i = 0; i < 8; i++) cyc(0, 1, 0, '0, 1, 1);
      // Redirect in the same cycle as an ack
      cyc(0, 1, 0, '0, 0, 1);
      cyc(0, 1, 1, 20'h00400, 1, 1);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, '0, 1, 1);
      // Reset while a request is being acked
      cyc(0, 1, 0, '0, 0, 1);
      cyc(1, 1, 0, '0, 1, 1);
      cyc(0, 0, 0, '0, 1, 1);
      // Run drops while holding; stays idle until run returns
      cyc(0, 1, 0, '0, 0, 1);
      cyc(0, 1, 0, '0, 1, 0);
      cyc(0, 0, 0, '0, 0, 0);
      cyc(0, 0, 0, '0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, '0, 1, 1);
      cyc(0, 1, 0, '0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, '0, 1, 1);
      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         logic          r_rst, r_run, r_rv, r_ack, r_rdy;
         logic [AW-1:0] r_tgt;
         r_rst = ($urandom_range(0, 199) == 0);
         r_run = ($urandom_range(0, 9) != 0);
         r_rv  = ($urandom_range(0, 24) == 0);
         r_ack = ($urandom_range(0, 2) != 0);
         r_rdy = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 2))
            0:       r_tgt = 20'hFFFFF - 20'($urandom_range(0, 3));
            1:       r_tgt = 20'($urandom);
            default: r_tgt = 20'h00400;
         endcase
         cyc(r_rst, r_run, r_rv, r_tgt, r_ack, r_rdy);
      end
      cyc(0, 0, 0, '0, 0, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
